// File: rtl/key_select_ctrl_pkg.sv
// Shared key/chord constants and the triad mask helper.
// Also used by vga_bitchange to decode the same mask.
package key_select_ctrl_pkg;

    localparam int NUM_KEYS      = 12;
    localparam int MAJ_THIRD     = 4;
    localparam int PERFECT_FIFTH = 7;

    localparam logic [3:0] KEY_C  = 4'd0;
    localparam logic [3:0] KEY_CS = 4'd1;
    localparam logic [3:0] KEY_D  = 4'd2;
    localparam logic [3:0] KEY_DS = 4'd3;
    localparam logic [3:0] KEY_E  = 4'd4;
    localparam logic [3:0] KEY_F  = 4'd5;
    localparam logic [3:0] KEY_FS = 4'd6;
    localparam logic [3:0] KEY_G  = 4'd7;
    localparam logic [3:0] KEY_GS = 4'd8;
    localparam logic [3:0] KEY_A  = 4'd9;
    localparam logic [3:0] KEY_AS = 4'd10;
    localparam logic [3:0] KEY_B  = 4'd11;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_CNT_PRESS,
        DB_PRESSED,
        DB_CNT_RELEASE
    } db_state_t;

    function automatic logic [4:0] wrap12(input logic [4:0] v);
        return (v >= 5'(NUM_KEYS)) ? v - 5'(NUM_KEYS) : v;
    endfunction

    function automatic logic [11:0] triad_mask(input logic [3:0] root,
                                               input logic       mode);
        logic [4:0]  w_third;
        logic [4:0]  w_fifth;
        logic [11:0] w_mask;
        w_third = wrap12({1'b0, root} + 5'(MAJ_THIRD));
        w_fifth = wrap12({1'b0, root} + 5'(PERFECT_FIFTH));
        w_mask  = 12'h001 << root;
        if (mode) begin
            w_mask = w_mask | (12'h001 << w_third[3:0])
                            | (12'h001 << w_fifth[3:0]);
        end
        return w_mask;
    endfunction

endpackage

// File: rtl/key_select_ctrl_if.sv
// Button inputs and key-select outputs of the key selector.
interface key_select_ctrl_if;
    logic        btn_up;
    logic        btn_c;
    logic [11:0] key_select;
    logic [3:0]  root_idx;
    logic        chord_mode;
    logic        sel_changed;

    modport master (
        output btn_up, btn_c,
        input  key_select, root_idx, chord_mode, sel_changed
    );

    modport slave (
        input  btn_up, btn_c,
        output key_select, root_idx, chord_mode, sel_changed
    );
endinterface

// File: rtl/key_select_ctrl_debounce.sv
// Two-flop synchronizer plus debounce FSM for one raw pushbutton.
// Accepts a press/release after DEBOUNCE_CYCLES stable samples.
module btn_debounce
    import key_select_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    // The sample that enters a CNT_ state is the first stable one.
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 2);

    logic            r_sync1;
    logic            r_sync2;
    db_state_t       r_state;
    logic [DW-1:0]   r_cnt;
    logic            r_press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= DB_IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            unique case (r_state)
                DB_IDLE: begin
                    if (r_sync2) begin
                        r_state <= DB_CNT_PRESS;
                        r_cnt   <= '0;
                    end
                end
                DB_CNT_PRESS: begin
                    if (!r_sync2) begin
                        r_state <= DB_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt >= DB_LAST) begin
                        r_state <= DB_PRESSED;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DB_PRESSED: begin
                    if (!r_sync2) begin
                        r_state <= DB_CNT_RELEASE;
                        r_cnt   <= '0;
                    end
                end
                DB_CNT_RELEASE: begin
                    if (r_sync2) begin
                        r_state <= DB_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt >= DB_LAST) begin
                        r_state <= DB_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= DB_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level = (r_state == DB_PRESSED) ||
                     (r_state == DB_CNT_RELEASE);
    assign o_press = r_press;

endmodule

// File: rtl/key_select_ctrl.sv
// Root-key / chord-mode selector driving the VGA keySelect mask.
// BtnU advances the root (with hold-to-repeat), BtnC toggles chord mode.
module key_select_ctrl
    import key_select_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic                     clk,
    input  logic                     reset,
    key_select_ctrl_if.slave         io_bus
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic          w_up_level;
    logic          w_up_press;
    logic          w_c_level;
    logic          w_c_press;
    logic          w_rep_fire;
    logic          w_adv;
    logic          w_tog;
    logic [3:0]    w_root_nxt;
    logic          w_mode_nxt;

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_armed;
    logic [3:0]    r_root;
    logic          r_mode;
    logic [11:0]   r_key;
    logic          r_sel_changed;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (io_bus.btn_up),
        .o_level (w_up_level),
        .o_press (w_up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (io_bus.btn_c),
        .o_level (w_c_level),
        .o_press (w_c_press)
    );

    // Counter tracks cycles since acceptance, then since the last repeat.
    assign w_rep_fire = w_up_level &&
        (r_rep_armed ? (r_rep_cnt == RW'(REPEAT_PERIOD))
                     : (r_rep_cnt == RW'(REPEAT_DELAY)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (!w_up_level) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= RW'(1);
            r_rep_armed <= 1'b1;
        end else if (r_rep_cnt != '1) begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    assign w_adv = w_up_press | w_rep_fire;
    assign w_tog = w_c_press & w_c_level;

    always_comb begin
        w_root_nxt = r_root;
        if (w_adv) begin
            w_root_nxt = (r_root == KEY_B) ? KEY_C : r_root + 4'd1;
        end
        w_mode_nxt = r_mode ^ w_tog;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_root        <= KEY_C;
            r_mode        <= 1'b0;
            r_key         <= 12'h001;
            r_sel_changed <= 1'b0;
        end else begin
            r_root        <= w_root_nxt;
            r_mode        <= w_mode_nxt;
            r_sel_changed <= w_adv | w_tog;
            if (w_adv | w_tog) begin
                r_key <= triad_mask(w_root_nxt, w_mode_nxt);
            end
        end
    end

    assign io_bus.key_select  = r_key;
    assign io_bus.root_idx    = r_root;
    assign io_bus.chord_mode  = r_mode;
    assign io_bus.sel_changed = r_sel_changed;

endmodule

// File: tb/tb_key_select_ctrl.sv
// Bench for key_select_ctrl: directed scenarios plus random button holds
// checked against a press-length model of debounce and auto-repeat.
module tb_key_select_ctrl;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   sel_cnt;
    int   m_root;
    bit   m_mode;

    key_select_ctrl_if kif ();

    key_select_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk    (clk),
        .reset  (rst),
        .io_bus (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kif.sel_changed === 1'b1) sel_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] exp_mask(input int r, input bit m);
        logic [11:0] v;
        v    = '0;
        v[r] = 1'b1;
        if (m) begin
            v[(r + 4) % 12] = 1'b1;
            v[(r + 7) % 12] = 1'b1;
        end
        return v;
    endfunction

    // Advances from a clean hold of h cycles: held level lasts h cycles.
    function automatic int n_adv(input int h);
        int n;
        n = 0;
        if (h >= D) begin
            for (int k = 0; k < h; k++) begin
                if (k == 0 || k == RD || (k > RD && (k - RD) % RP == 0))
                    n++;
            end
        end
        return n;
    endfunction

    task automatic press(input bit up, input bit c, input int h);
        @(posedge clk);
        #1;
        kif.btn_up = up;
        kif.btn_c  = c;
        repeat (h) @(posedge clk);
        #1;
        kif.btn_up = 1'b0;
        kif.btn_c  = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic model_press(input bit up, input bit c, input int h);
        int a;
        a = up ? n_adv(h) : 0;
        m_root = (m_root + a) % 12;
        if (c && h >= D) m_mode = ~m_mode;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_root = 0;
        m_mode = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        kif.btn_up = 1'b0;
        kif.btn_c  = 1'b0;
        sel_cnt    = 0;
        m_root     = 0;
        m_mode     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({kif.key_select, kif.root_idx, kif.chord_mode, kif.sel_changed}
            !== {12'h001, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got ks=%h root=%0d chord=%b sc=%b",
                     kif.key_select, kif.root_idx, kif.chord_mode,
                     kif.sel_changed);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_glitch_and_single();
        int s0;
        s0 = sel_cnt;
        press(1'b1, 1'b0, 3);
        n_checks++;
        if (kif.root_idx !== 4'd0 || sel_cnt != s0) begin
            n_fail++;
            $display("FAIL glitch: root=%0d pulses=%0d want root=0 pulses=0",
                     kif.root_idx, sel_cnt - s0);
        end
        press(1'b1, 1'b0, 6);
        model_press(1'b1, 1'b0, 6);
        n_checks++;
        if (kif.root_idx !== 4'd1 || kif.key_select !== 12'h002) begin
            n_fail++;
            $display("FAIL single_press: root=%0d ks=%h want 1 / 002",
                     kif.root_idx, kif.key_select);
        end
        n_checks++;
        if (sel_cnt - s0 != 1) begin
            n_fail++;
            $display("FAIL single_pulse: pulses=%0d want 1", sel_cnt - s0);
        end
    endtask

    task automatic test_latency();
        int r0;
        r0 = m_root;
        @(posedge clk);
        #1;
        kif.btn_up = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (kif.root_idx !== 4'(r0) || kif.sel_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: root=%0d sc=%b want %0d/0",
                     kif.root_idx, kif.sel_changed, r0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (kif.root_idx !== 4'((r0 + 1) % 12) || kif.sel_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_edge: root=%0d sc=%b want %0d/1",
                     kif.root_idx, kif.sel_changed, (r0 + 1) % 12);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (kif.sel_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_pulse_width: sc=%b want 0", kif.sel_changed);
        end
        kif.btn_up = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        #1;
        model_press(1'b1, 1'b0, 8);
    endtask

    task automatic test_async_reset();
        while (m_root != 5) begin
            press(1'b1, 1'b0, 6);
            model_press(1'b1, 1'b0, 6);
        end
        n_checks++;
        if (kif.root_idx !== 4'd5) begin
            n_fail++;
            $display("FAIL pre_reset_root: got %0d want 5", kif.root_idx);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({kif.key_select, kif.root_idx, kif.chord_mode, kif.sel_changed}
            !== {12'h001, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got ks=%h root=%0d chord=%b sc=%b",
                     kif.key_select, kif.root_idx, kif.chord_mode,
                     kif.sel_changed);
        end
        @(negedge clk);
        rst    = 1'b0;
        m_root = 0;
        m_mode = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            press(1'b1, 1'b0, 6);
            model_press(1'b1, 1'b0, 6);
            if (i == 10) begin
                n_checks++;
                if (kif.root_idx !== 4'd11 || kif.key_select !== 12'h800) begin
                    n_fail++;
                    $display("FAIL wrap_top: root=%0d ks=%h want 11/800",
                             kif.root_idx, kif.key_select);
                end
            end
        end
        n_checks++;
        if (kif.root_idx !== 4'd0 || kif.key_select !== 12'h001) begin
            n_fail++;
            $display("FAIL wrap: root=%0d ks=%h want 0/001",
                     kif.root_idx, kif.key_select);
        end
    endtask

    task automatic test_chord();
        do_reset();
        press(1'b0, 1'b1, 6);
        model_press(1'b0, 1'b1, 6);
        n_checks++;
        if (kif.chord_mode !== 1'b1 || kif.key_select !== 12'h091) begin
            n_fail++;
            $display("FAIL chord_root0: chord=%b ks=%h want 1/091",
                     kif.chord_mode, kif.key_select);
        end
        repeat (5) begin
            press(1'b1, 1'b0, 6);
            model_press(1'b1, 1'b0, 6);
        end
        n_checks++;
        if (kif.key_select !== 12'h221) begin
            n_fail++;
            $display("FAIL chord_root5: ks=%h want 221", kif.key_select);
        end
        repeat (3) begin
            press(1'b1, 1'b0, 6);
            model_press(1'b1, 1'b0, 6);
        end
        n_checks++;
        if (kif.key_select !== 12'h109) begin
            n_fail++;
            $display("FAIL chord_root8: ks=%h want 109", kif.key_select);
        end
    endtask

    task automatic test_repeat();
        int s0;
        do_reset();
        s0 = sel_cnt;
        press(1'b1, 1'b0, 34);
        model_press(1'b1, 1'b0, 34);
        n_checks++;
        if (kif.root_idx !== 4'd3 || kif.key_select !== 12'h008) begin
            n_fail++;
            $display("FAIL repeat_root: root=%0d ks=%h want 3/008",
                     kif.root_idx, kif.key_select);
        end
        n_checks++;
        if (sel_cnt - s0 != 3) begin
            n_fail++;
            $display("FAIL repeat_pulses: got %0d want 3", sel_cnt - s0);
        end
    endtask

    task automatic test_simultaneous();
        int s0;
        do_reset();
        s0 = sel_cnt;
        press(1'b1, 1'b1, 6);
        model_press(1'b1, 1'b1, 6);
        n_checks++;
        if (kif.root_idx !== 4'd1 || kif.chord_mode !== 1'b1 ||
            kif.key_select !== exp_mask(1, 1'b1)) begin
            n_fail++;
            $display("FAIL simultaneous: root=%0d chord=%b ks=%h want 1/1/%h",
                     kif.root_idx, kif.chord_mode, kif.key_select,
                     exp_mask(1, 1'b1));
        end
        n_checks++;
        if (sel_cnt - s0 != 1) begin
            n_fail++;
            $display("FAIL simultaneous_pulse: got %0d want 1", sel_cnt - s0);
        end
    endtask

    task automatic test_random();
        int s0;
        int h;
        int sel;
        int want;
        bit up;
        bit c;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            h   = int'($urandom_range(1, 45));
            sel = int'($urandom_range(0, 2));
            up  = (sel != 1);
            c   = (sel != 0);
            s0  = sel_cnt;
            press(up, c, h);
            model_press(up, c, h);
            want = up ? n_adv(h) : ((h >= D) ? 1 : 0);
            n_checks++;
            if (kif.root_idx !== 4'(m_root) || kif.chord_mode !== m_mode ||
                kif.key_select !== exp_mask(m_root, m_mode)) begin
                n_fail++;
                $display("FAIL random_%0d: h=%0d up=%b c=%b got %0d/%b/%h want %0d/%b/%h",
                         i, h, up, c, kif.root_idx, kif.chord_mode,
                         kif.key_select, m_root, m_mode,
                         exp_mask(m_root, m_mode));
            end
            n_checks++;
            if (sel_cnt - s0 != want) begin
                n_fail++;
                $display("FAIL random_pulses_%0d: h=%0d got %0d want %0d",
                         i, h, sel_cnt - s0, want);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_glitch_and_single();
        test_latency();
        test_async_reset();
        test_wrap();
        test_chord();
        test_repeat();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
